// File: rtl/seg7_pkg.sv
// Shared constants and digit type for the 8-digit seven-segment scan controller.
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam logic [6:0] SEG_BLANK  = 7'h00;

  // Active-high segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       dp;
    logic [3:0] val;
  } digit_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_PATTERN[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Digit multiplex scheduler: prescaled slots, enabled-digit rotation, anti-ghost
// blanking, leading-zero suppression and a frame-atomic double-buffered digit store.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_val,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [7:0] en_mask,
  input  logic       lz_en,
  output logic [7:0] AN,
  output logic [7:0] CA,
  output logic       commit_pend,
  output logic       frame_done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]         pre;
  logic [2:0]            slot;
  logic [2:0]            nxt_slot;
  digit_t                shadow [NUM_DIGITS];
  digit_t                active [NUM_DIGITS];
  logic                  tick, wrap, mask_any, apply;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [6:0]            seg;

  assign tick     = (pre == PW'(DIV - 1));
  assign mask_any = |en_mask;

  // Smallest forward distance to an enabled digit wins; distance 8 is the slot itself.
  always_comb begin
    logic [2:0] cand;
    nxt_slot = slot;
    cand     = slot;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      cand = 3'(int'(slot) + k);
      if (en_mask[cand]) nxt_slot = cand;
    end
  end

  assign wrap  = mask_any && (nxt_slot <= slot);
  assign apply = tick && wrap && commit_pend;

  // A digit blanks when it and every enabled digit above it hold zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_blank[i] = lz_en && (active[i].val == 4'h0) && zero_above;
      if (en_mask[i] && (active[i].val != 4'h0)) zero_above = 1'b0;
    end
  end

  seg7_hex_decode u_dec (
    .hex (active[slot].val),
    .seg (seg)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre         <= '0;
      slot        <= '0;
      AN          <= AN_OFF;
      CA          <= 8'hFF;
      commit_pend <= 1'b0;
      frame_done  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (tick) begin
        pre  <= '0;
        slot <= nxt_slot;
      end else begin
        pre <= pre + PW'(1);
      end

      frame_done <= tick && wrap;

      // Copy reads shadow before this edge's write lands, so a same-edge write is excluded.
      if (apply) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
        commit_pend <= 1'b0;
      end else if (commit) begin
        commit_pend <= 1'b1;
      end

      if (wr_en) shadow[wr_idx] <= '{dp: wr_dp, val: wr_val};

      if (!mask_any) begin
        AN <= AN_OFF;
        CA <= 8'hFF;
      end else begin
        AN <= (pre < PW'(BLANK_CYC)) ? AN_OFF : ~(8'h01 << slot);
        CA <= ~{active[slot].dp, lz_blank[slot] ? SEG_BLANK : seg};
      end
    end
  end

endmodule
